// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if
//   Bundles the signals of the PS/2 host transmitter:
//   - command handshake: tx_valid, tx_byte -> tx_ready, tx_busy, tx_done,
//     tx_ack, tx_error
//   - PS/2 lines: ps2_clk_in, ps2_data_in (sampled pads) and
//     ps2_clk_oe, ps2_data_oe (1 = pull the line low)
//   modport slave  : the transmitter itself
//   modport master : the processor / pad environment around it
interface ps2_host_tx_if;
  logic       tx_valid;
  logic [7:0] tx_byte;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_ack;
  logic       tx_error;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;

  modport master (
    output tx_valid, tx_byte, ps2_clk_in, ps2_data_in,
    input  tx_ready, tx_busy, tx_done, tx_ack, tx_error, ps2_clk_oe, ps2_data_oe
  );

  modport slave (
    input  tx_valid, tx_byte, ps2_clk_in, ps2_data_in,
    output tx_ready, tx_busy, tx_done, tx_ack, tx_error, ps2_clk_oe, ps2_data_oe
  );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx
//   PS/2 host-to-device transmitter. Sends one command byte to the keyboard:
//   inhibit (clock low), request-to-send (data low), then shifts d0..d7, odd
//   parity and stop on device-generated falling clock edges, samples the
//   device ACK, waits for bus idle and reports the result.
//   Lines are only ever pulled low through registered output enables.
// Ports
//   clk   : system clock
//   reset : asynchronous, active-high reset (releases both lines at once)
//   bus   : ps2_host_tx_if.slave (command handshake + PS/2 line signals)
// Parameters
//   INHIBIT_CYCLES : clocks the PS/2 clock is held low before request-to-send
//   TIMEOUT_CYCLES : max clocks between device falling edges before abort
//   SYNC_STAGES    : synchronizer depth on the PS/2 inputs (>= 2)
// Build option
//   PS2_HOST_TX_RETRY_EN : when defined, a NACK or timeout re-runs the frame
//   once with the same byte; tx_done only follows the final attempt.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic         clk,
  input  logic         reset,
  ps2_host_tx_if.slave bus
);
  localparam int MAX_CNT = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_START, S_RTS, S_SHIFT, S_ACK, S_WAIT_IDLE, S_DONE
  } state_t;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  state_t                 state;
  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_prev, clk_s, data_s, fe;
  logic [CNT_W-1:0]       cnt;
  logic [3:0]             bitcnt;
  logic                   idle_seen, nack_q;
  logic [8:0]             frame_q, shift_q;
  logic                   accept, active, shift_en, retry_ok;
  logic                   end_tmo, end_wait, end_fail, end_ok;
  logic                   clk_oe_q, data_oe_q, ready_q, busy_q, done_q, ack_q, err_q;

  assign bus.ps2_clk_oe  = clk_oe_q;
  assign bus.ps2_data_oe = data_oe_q;
  assign bus.tx_ready    = ready_q;
  assign bus.tx_busy     = busy_q;
  assign bus.tx_done     = done_q;
  assign bus.tx_ack      = ack_q;
  assign bus.tx_error    = err_q;

  // ---- input synchronizers (preset high = idle bus) ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], bus.ps2_clk_in};
      data_sync <= {data_sync[SYNC_STAGES-2:0], bus.ps2_data_in};
      clk_prev  <= clk_s;
    end
  end

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];
  assign fe     = clk_prev & ~clk_s;

  assign accept   = bus.tx_valid & ready_q;
  assign active   = state inside {S_RTS, S_SHIFT, S_ACK, S_WAIT_IDLE};
  // A falling edge in the same cycle rescues the transfer from timing out.
  assign end_tmo  = active & ~fe & (cnt == TMO_LAST);
  assign end_wait = (state == S_WAIT_IDLE) & clk_s & data_s & idle_seen;
  assign end_fail = end_tmo | (end_wait & nack_q);
  assign end_ok   = end_wait & ~nack_q & ~end_tmo;
  // The parity bit is the last one shifted; the stop bit is driven separately.
  assign shift_en = fe & ((state == S_RTS) | ((state == S_SHIFT) & (bitcnt != 4'd9)));

`ifdef PS2_HOST_TX_RETRY_EN
  logic retried;
  assign retry_ok = ~retried;
`else
  assign retry_ok = 1'b0;
`endif

  // ---- frame data (not reset: only meaningful after an accept) ----
  always_ff @(posedge clk) begin
    if (accept)
      frame_q <= {odd_parity(bus.tx_byte), bus.tx_byte};
    // Reloaded at every start so a retry resends the identical frame.
    if (state == S_START)
      shift_q <= frame_q;
    else if (shift_en)
      shift_q <= {1'b1, shift_q[8:1]};
  end

  // ---- control FSM ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bitcnt    <= '0;
      idle_seen <= 1'b0;
      nack_q    <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
      retried   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (active)
        cnt <= fe ? '0 : cnt + CNT_W'(1);

      case (state)
        S_IDLE: begin
          if (accept) begin
            state    <= S_INHIBIT;
            clk_oe_q <= 1'b1;
            cnt      <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
            retried  <= 1'b0;
`endif
          end
        end
        S_INHIBIT: begin
          if (cnt == INH_LAST) begin
            data_oe_q <= 1'b1;
            state     <= S_START;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_START: begin
          // Start bit is already low; releasing the clock is the request-to-send.
          clk_oe_q <= 1'b0;
          cnt      <= '0;
          bitcnt   <= '0;
          state    <= S_RTS;
        end
        S_RTS: begin
          if (fe) begin
            data_oe_q <= ~shift_q[0];
            bitcnt    <= 4'd1;
            state     <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (fe) begin
            if (bitcnt == 4'd9) begin
              data_oe_q <= 1'b0;
              state     <= S_ACK;
            end else begin
              data_oe_q <= ~shift_q[0];
              bitcnt    <= bitcnt + 4'd1;
            end
          end
        end
        S_ACK: begin
          if (fe) begin
            nack_q    <= data_s;
            idle_seen <= 1'b0;
            state     <= S_WAIT_IDLE;
          end
        end
        S_WAIT_IDLE: begin
          idle_seen <= clk_s & data_s;
        end
        S_DONE: begin
          state   <= S_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase

      // Completion overrides whatever the state branch scheduled.
      if (end_fail) begin
        clk_oe_q  <= 1'b0;
        data_oe_q <= 1'b0;
        cnt       <= '0;
        if (retry_ok) begin
`ifdef PS2_HOST_TX_RETRY_EN
          retried <= 1'b1;
`endif
          clk_oe_q <= 1'b1;
          state    <= S_INHIBIT;
        end else begin
          state  <= S_DONE;
          done_q <= 1'b1;
          ack_q  <= 1'b0;
          err_q  <= 1'b1;
        end
      end else if (end_ok) begin
        state  <= S_DONE;
        done_q <= 1'b1;
        ack_q  <= 1'b1;
        err_q  <= 1'b0;
      end
    end
  end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the processor side to the keyboard.
- Counterpart of the keyboard receive driver: the receiver decodes device-to-host frames, this block generates host-to-device frames on the same PS/2 clock/data lines.
- Open-drain style: the block only drives lines low via output-enables; pads/pull-ups are handled at top level.
- tx_busy lets the receive path ignore the bus while a host frame is in flight.

Parameters:
- INHIBIT_CYCLES, 5000, system clocks the PS/2 clock is held low before request-to-send (100 us at 50 MHz).
- TIMEOUT_CYCLES, 1000000, maximum system clocks between PS/2 falling edges (or from release to first edge) before abort (20 ms at 50 MHz).
- SYNC_STAGES, 2, synchronizer flops on ps2_clk_in and ps2_data_in (minimum 2).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ps2_clk_in  in  1  sampled PS/2 clock line
- ps2_data_in  in  1  sampled PS/2 data line
- ps2_clk_oe  out  1  1 = pull PS/2 clock low
- ps2_data_oe  out  1  1 = pull PS/2 data low
- tx_valid  in  1  command byte request
- tx_byte  in  8  command byte
- tx_ready  out  1  block can accept a byte
- tx_busy  out  1  frame in progress (any state other than IDLE)
- tx_done  out  1  one-cycle pulse at end of transaction
- tx_ack  out  1  valid with tx_done: 1 = device acknowledged
- tx_error  out  1  valid with tx_done: 1 = timeout or NACK

Behaviour:
- Reset: state IDLE, ps2_clk_oe=0, ps2_data_oe=0, tx_ready=1, tx_busy=0, tx_done=0, tx_ack=0, tx_error=0, counters=0, synchronizers preset to 1.
- Input handling: ps2_clk_in and ps2_data_in pass through SYNC_STAGES flops. A falling edge (fe) is synchronized clock previous=1, current=0.
- Handshake: a byte is accepted when tx_valid & tx_ready. tx_ready=1 only in IDLE. The byte is latched; a 9-bit shift register is loaded with {odd parity, tx_byte}, where parity = ~^tx_byte. tx_valid while busy is ignored, not queued.
- IDLE -> INHIBIT on accept.
- INHIBIT: clk_oe=1, data_oe=0. After INHIBIT_CYCLES cycles: data_oe=1 (start bit), clk_oe=0 next cycle. Go to RTS with bit counter=0 and the timeout counter cleared.
- RTS: data_oe=1 and waits for first fe.
  - On fe: drive bit 0 (data_oe = ~shift[0]) and enter SHIFT.
- SHIFT: on each fe, advance to the next bit, so the bit value changes while the device holds clock low. Sequence is d0..d7 LSB first, then parity. On the 10th fe, drive stop: data_oe=0. Then ACK.
- ACK: on the next fe (11th), sample the synchronized data. 0 = ack, 1 = NACK. Go to WAIT_IDLE.
- WAIT_IDLE: wait until synchronized clock=1 and data=1 for 2 consecutive cycles, then DONE.
- DONE: one cycle. tx_done=1, tx_ack/tx_error per the result. Then IDLE.
- Timeout: the counter resets on every fe. In RTS/SHIFT/ACK/WAIT_IDLE, reaching TIMEOUT_CYCLES releases both lines (oe=0) and goes to DONE with tx_error=1, tx_ack=0.
- tx_ack and tx_error hold their value until the next accept, then clear.
- Reset mid-frame: lines released immediately (asynchronous), no tx_done is generated, and the block returns to IDLE.
- ps2_*_oe are registered outputs, never combinational from inputs.

Optional Feature:
- Macro: PS2_HOST_TX_RETRY_EN.
- Defined: on NACK or timeout, the block automatically re-runs the frame once from INHIBIT with the same byte. tx_done is asserted only after the final attempt; tx_error=1 only if both attempts fail. A retry flag is cleared on accept.
- Undefined: a single attempt; the first failure reports tx_error directly.

Test Plan:
- Send 0xED, device model clocks at 12.5 kHz and acks. Required response:
  - clk_oe low for exactly 5000 cycles, then data_oe=1.
  - Device samples data 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - ACK low gives tx_done pulse with tx_ack=1, tx_error=0, then tx_ready=1.
- Send 0x00: required parity bit=1, stop=1. Send 0x01: required parity bit=0. Device sample order verified LSB first.
- Device never clocks after release. Required: tx_done after 1000000 cycles in RTS with tx_error=1; oe both 0. With RETRY_EN, a second INHIBIT phase occurs and tx_done comes after roughly 2× that.
- Device NACKs (data high on 11th edge). Required: tx_ack=0, tx_error=1. With RETRY_EN and an ack on the second try: tx_ack=1, tx_error=0, single tx_done.
- Assert reset during SHIFT after the 4th bit. Required: oe=0 in the same cycle, no tx_done, tx_ready=1. A following 0xFF transfer completes correctly.
- Pulse tx_valid with 0xAA while busy sending 0xF4. Required: 0xAA ignored, only the 0xF4 frame appears on the bus, one tx_done.
